// File: rtl/control_sequencer_if.sv
// Control-word bundle between the sequencer and the datapath.
// Carries opcode/flags/step_en in and every strobe out.
interface control_sequencer_if;
   logic       step_en;
   logic [3:0] ir_opcode;
   logic       flag_c;
   logic       flag_z;
   logic       pc_enable;
   logic       pc_load;
   logic       oe_pc;
   logic       load_mar;
   logic       oe_ram;
   logic       load_ram;
   logic       load_ir;
   logic       oe_ir;
   logic       load_a;
   logic       oe_a;
   logic       load_b;
   logic       oe_alu;
   logic       alu_sub;
   logic       load_flags;
   logic       load_out;
   logic       halt;

   modport master (
      input  step_en, ir_opcode, flag_c, flag_z,
      output pc_enable, pc_load, oe_pc, load_mar,
      output oe_ram, load_ram, load_ir, oe_ir,
      output load_a, oe_a, load_b, oe_alu,
      output alu_sub, load_flags, load_out, halt
   );

   modport slave (
      output step_en, ir_opcode, flag_c, flag_z,
      input  pc_enable, pc_load, oe_pc, load_mar,
      input  oe_ram, load_ram, load_ir, oe_ir,
      input  load_a, oe_a, load_b, oe_alu,
      input  alu_sub, load_flags, load_out, halt
   );
endinterface

// File: rtl/control_sequencer.sv
// Microcode step sequencer for an 8-bit bus CPU.
// Step counter + halted flag; control word decoded combinationally.
module control_sequencer (
   input  logic                        i_clk,
   input  logic                        i_reset,
   control_sequencer_if.master         io_ctl
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } step_t;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_LDA = 4'd1;
   localparam logic [3:0] OP_ADD = 4'd2;
   localparam logic [3:0] OP_SUB = 4'd3;
   localparam logic [3:0] OP_STA = 4'd4;
   localparam logic [3:0] OP_LDI = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;
   localparam logic [3:0] OP_JC  = 4'd7;
   localparam logic [3:0] OP_JZ  = 4'd8;
   localparam logic [3:0] OP_OUT = 4'd14;
   localparam logic [3:0] OP_HLT = 4'd15;

   step_t r_step;
   step_t w_step_nxt;
   logic  r_halted;
   logic  w_halted_nxt;

   logic w_pc_enable, w_pc_load, w_oe_pc, w_load_mar;
   logic w_oe_ram, w_load_ram, w_load_ir, w_oe_ir;
   logic w_load_a, w_oe_a, w_load_b, w_oe_alu;
   logic w_alu_sub, w_load_flags, w_load_out, w_halt;
   logic w_len4, w_len5;

   assign w_len4 = (io_ctl.ir_opcode == OP_LDA)
                || (io_ctl.ir_opcode == OP_STA);
   assign w_len5 = (io_ctl.ir_opcode == OP_ADD)
                || (io_ctl.ir_opcode == OP_SUB);

   // State register: reset wins over halt and step_en.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_step   <= S0;
         r_halted <= 1'b0;
      end else begin
         r_step   <= w_step_nxt;
         r_halted <= w_halted_nxt;
      end
   end

   // Next step: advance only when enabled and not halted.
   always_comb begin
      w_step_nxt   = r_step;
      w_halted_nxt = r_halted;
      if (!r_halted && io_ctl.step_en) begin
         case (r_step)
            S0: w_step_nxt = S1;
            S1: w_step_nxt = S2;
            S2: begin
               if (io_ctl.ir_opcode == OP_HLT)
                  w_halted_nxt = 1'b1;
               else if (w_len4 || w_len5)
                  w_step_nxt = S3;
               else
                  w_step_nxt = S0;
            end
            S3: w_step_nxt = w_len5 ? S4 : S0;
            S4: w_step_nxt = S0;
            default: w_step_nxt = S0;
         endcase
      end
   end

   // Control word decode; everything low while reset is held.
   always_comb begin
      w_pc_enable  = 1'b0;
      w_pc_load    = 1'b0;
      w_oe_pc      = 1'b0;
      w_load_mar   = 1'b0;
      w_oe_ram     = 1'b0;
      w_load_ram   = 1'b0;
      w_load_ir    = 1'b0;
      w_oe_ir      = 1'b0;
      w_load_a     = 1'b0;
      w_oe_a       = 1'b0;
      w_load_b     = 1'b0;
      w_oe_alu     = 1'b0;
      w_alu_sub    = 1'b0;
      w_load_flags = 1'b0;
      w_load_out   = 1'b0;
      w_halt       = 1'b0;
      if (i_reset) begin
         w_halt = 1'b0;
      end else if (r_halted) begin
         w_halt = 1'b1;
      end else begin
         case (r_step)
            S0: begin
               w_oe_pc    = 1'b1;
               w_load_mar = 1'b1;
            end
            S1: begin
               w_oe_ram    = 1'b1;
               w_load_ir   = 1'b1;
               w_pc_enable = 1'b1;
            end
            S2: begin
               case (io_ctl.ir_opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     w_oe_ir    = 1'b1;
                     w_load_mar = 1'b1;
                  end
                  OP_LDI: begin
                     w_oe_ir  = 1'b1;
                     w_load_a = 1'b1;
                  end
                  OP_OUT: begin
                     w_oe_a     = 1'b1;
                     w_load_out = 1'b1;
                  end
                  OP_JMP: begin
                     w_oe_ir   = 1'b1;
                     w_pc_load = 1'b1;
                  end
                  OP_JC: begin
                     w_oe_ir   = io_ctl.flag_c;
                     w_pc_load = io_ctl.flag_c;
                  end
                  OP_JZ: begin
                     w_oe_ir   = io_ctl.flag_z;
                     w_pc_load = io_ctl.flag_z;
                  end
                  OP_NOP, OP_HLT: w_halt = 1'b0;
                  default:        w_halt = 1'b0;
               endcase
            end
            S3: begin
               if (io_ctl.ir_opcode == OP_LDA) begin
                  w_oe_ram = 1'b1;
                  w_load_a = 1'b1;
               end else if (w_len5) begin
                  w_oe_ram = 1'b1;
                  w_load_b = 1'b1;
               end else if (io_ctl.ir_opcode == OP_STA) begin
                  w_oe_a     = 1'b1;
                  w_load_ram = 1'b1;
               end
            end
            S4: begin
               if (w_len5) begin
                  w_oe_alu     = 1'b1;
                  w_load_a     = 1'b1;
                  w_load_flags = 1'b1;
                  w_alu_sub    = (io_ctl.ir_opcode == OP_SUB);
               end
            end
            default: w_halt = 1'b0;
         endcase
      end
   end

   assign io_ctl.pc_enable  = w_pc_enable;
   assign io_ctl.pc_load    = w_pc_load;
   assign io_ctl.oe_pc      = w_oe_pc;
   assign io_ctl.load_mar   = w_load_mar;
   assign io_ctl.oe_ram     = w_oe_ram;
   assign io_ctl.load_ram   = w_load_ram;
   assign io_ctl.load_ir    = w_load_ir;
   assign io_ctl.oe_ir      = w_oe_ir;
   assign io_ctl.load_a     = w_load_a;
   assign io_ctl.oe_a       = w_oe_a;
   assign io_ctl.load_b     = w_load_b;
   assign io_ctl.oe_alu     = w_oe_alu;
   assign io_ctl.alu_sub    = w_alu_sub;
   assign io_ctl.load_flags = w_load_flags;
   assign io_ctl.load_out   = w_load_out;
   assign io_ctl.halt       = w_halt;

endmodule
